// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with dead-cycle turnaround.
// Optional macro HOLD_LIMIT_EN: preempt an owner after MAX_HOLD grant cycles when others wait.
//
// state | meaning
// IDLE  | bus free, next requester picked round-robin from last+1
// GRANT | one requester owns the bus (gnt/oe one-hot, stable)
// TURN  | bus released, all drivers off for TURN_CYCLES cycles
module tri_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 8,
    localparam int OWNER_W    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   oe,
    output logic [OWNER_W-1:0] owner_id,
    output logic               bus_busy
);

    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    if (N_REQ < 2 || TURN_CYCLES < 1 || MAX_HOLD < 1) begin : g_param_check
        $error("tri_bus_arbiter: illegal parameter values");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [OWNER_W-1:0] owner_nxt;
    logic [OWNER_W-1:0] last, last_nxt;
    logic [OWNER_W-1:0] pick_idx, scan_idx;
    logic               pick_vld;
    logic [TURN_W-1:0]  turn_cnt, turn_nxt;
    logic               release_bus;

`ifdef HOLD_LIMIT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic               others_pending;

    assign others_pending = |(req & ~gnt);
`endif

    // Rotating priority scan: first set request strictly after the previous owner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            scan_idx = OWNER_W'((int'(last) + i) % N_REQ);
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        owner_nxt   = owner_id;
        last_nxt    = last;
        turn_nxt    = turn_cnt;
        release_bus = 1'b0;
`ifdef HOLD_LIMIT_EN
        hold_nxt    = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt         = GRANT;
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    owner_nxt         = pick_idx;
                    last_nxt          = pick_idx;
`ifdef HOLD_LIMIT_EN
                    hold_nxt          = '0;
`endif
                end
            end
            GRANT: begin
`ifdef HOLD_LIMIT_EN
                if (hold_cnt != HOLD_W'(MAX_HOLD - 1)) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
                if (!req[owner_id]) begin
                    release_bus = 1'b1;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1) && others_pending) begin
                    release_bus = 1'b1;
                end
`else
                release_bus = !req[owner_id];
`endif
                if (release_bus) begin
                    state_nxt = TURN;
                    gnt_nxt   = '0;
                    turn_nxt  = TURN_W'(TURN_CYCLES - 1);
                end
            end
            TURN: begin
                if (turn_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    turn_nxt = turn_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            last     <= OWNER_W'(N_REQ - 1);
            turn_cnt <= '0;
`ifdef HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            owner_id <= owner_nxt;
            last     <= last_nxt;
            turn_cnt <= turn_nxt;
`ifdef HOLD_LIMIT_EN
            hold_cnt <= hold_nxt;
`endif
        end
    end

    assign oe       = gnt;
    assign bus_busy = |gnt;

endmodule
